// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer: turns a 4-bit 74181-style combinational slice into a
// multi-cycle WIDTH-bit ripple ALU. Operands are latched through a valid/ready
// handshake, one nibble per cycle is presented LSB-first with the slice carry
// fed back into the next nibble, and the assembled word is offered through a
// second valid/ready handshake.
module alu_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_s,
  input  logic             in_m,
  input  logic             in_cn,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [3:0]       alu_s,
  output logic             alu_m,
  output logic             alu_cn,
  input  logic [3:0]       alu_f,
  input  logic             alu_cn_out,
  input  logic             alu_a_eq_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_f,
  output logic             out_cn,
  output logic             out_a_eq_b
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CNT_W   = $clog2(NIBBLES);
  localparam logic [CNT_W-1:0] LAST_NIBBLE = CNT_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [3:0]         s_q;
  logic               m_q;
  logic               carry_q;
  logic               eq_q, eq_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]   outF_q;
  logic               outCn_q;
  logic               outEq_q;
  logic               lastNibble;

  assign lastNibble = (cnt_q == LAST_NIBBLE);

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: accept in IDLE, walk every nibble in RUN, hold DONE until consumed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_d = RUN;
      RUN:     if (lastNibble) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags and slice drive; the slice sees zeros whenever it is not in use.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    alu_a     = 4'h0;
    alu_b     = 4'h0;
    alu_s     = 4'h0;
    alu_m     = 1'b0;
    alu_cn    = 1'b0;
    if (state_q == RUN) begin
      alu_a  = a_q[4*cnt_q +: 4];
      alu_b  = b_q[4*cnt_q +: 4];
      alu_s  = s_q;
      alu_m  = m_q;
      alu_cn = carry_q;
    end
  end

  // Partial word with the current slice result merged in, plus the running A=B flag.
  always_comb begin
    work_d                 = work_q;
    work_d[4*cnt_q +: 4]   = alu_f;
    eq_d                   = eq_q & alu_a_eq_b;
  end

  // Operand capture, per-nibble accumulation, and the result registers that only
  // update on the final nibble so the consumer sees a stable word.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= 4'h0;
      m_q     <= 1'b0;
      carry_q <= 1'b0;
      eq_q    <= 1'b0;
      cnt_q   <= '0;
      work_q  <= '0;
      outF_q  <= '0;
      outCn_q <= 1'b0;
      outEq_q <= 1'b0;
    end else if (state_q == IDLE) begin
      if (in_valid) begin
        a_q     <= in_a;
        b_q     <= in_b;
        s_q     <= in_s;
        m_q     <= in_m;
        carry_q <= in_cn;
        eq_q    <= 1'b1;
        cnt_q   <= '0;
      end
    end else if (state_q == RUN) begin
      work_q  <= work_d;
      carry_q <= alu_cn_out;
      eq_q    <= eq_d;
      if (lastNibble) begin
        outF_q  <= work_d;
        outCn_q <= alu_cn_out;
        outEq_q <= eq_d;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign out_f      = outF_q;
  assign out_cn     = outCn_q;
  assign out_a_eq_b = outEq_q;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// tb_alu_nibble_sequencer: drives the sequencer against a behavioural 74181
// slice and compares every observable against a word-level reference that
// evaluates the selected 74181 function directly on the full operands.
module tb_alu_nibble_sequencer;

  localparam int WIDTH   = 16;
  localparam int NIBBLES = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic [3:0]       in_s;
  logic             in_m, in_cn;
  logic [3:0]       alu_a, alu_b, alu_s;
  logic             alu_m, alu_cn;
  logic [3:0]       alu_f;
  logic             alu_cn_out, alu_a_eq_b;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] out_f;
  logic             out_cn, out_a_eq_b;

  int               passCount  = 0;
  int               checkCount = 0;
  logic [15:0]      lastF;
  logic             lastCn, lastEq;
  logic [16:0]      aluRes;

  alu_nibble_sequencer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_s       (in_s),
    .in_m       (in_m),
    .in_cn      (in_cn),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_s      (alu_s),
    .alu_m      (alu_m),
    .alu_cn     (alu_cn),
    .alu_f      (alu_f),
    .alu_cn_out (alu_cn_out),
    .alu_a_eq_b (alu_a_eq_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_f      (out_f),
    .out_cn     (out_cn),
    .out_a_eq_b (out_a_eq_b)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // 74181 function table (active-high data) evaluated over the low nbits bits.
  // Returns {Cn+4, F}; Cn and Cn+4 are active-low carries as on the real part.
  function automatic logic [16:0] evalOp(input logic [15:0] a, input logic [15:0] b,
                                         input logic [3:0] s, input logic m,
                                         input logic cn, input int nbits);
    logic [31:0] wa, wb, mask, x, y, sum, lg, f;
    wa   = {16'h0, a};
    wb   = {16'h0, b};
    mask = (32'h1 << nbits) - 32'h1;
    x    = wa;
    y    = 32'h0;
    lg   = 32'h0;
    case (s)
      4'h0: begin x = wa;        y = 32'h0;     end
      4'h1: begin x = wa | wb;   y = 32'h0;     end
      4'h2: begin x = wa | ~wb;  y = 32'h0;     end
      4'h3: begin x = 32'h0;     y = mask;      end
      4'h4: begin x = wa;        y = wa & ~wb;  end
      4'h5: begin x = wa | wb;   y = wa & ~wb;  end
      4'h6: begin x = wa;        y = ~wb;       end
      4'h7: begin x = wa & ~wb;  y = mask;      end
      4'h8: begin x = wa;        y = wa & wb;   end
      4'h9: begin x = wa;        y = wb;        end
      4'hA: begin x = wa | ~wb;  y = wa & wb;   end
      4'hB: begin x = wa & wb;   y = mask;      end
      4'hC: begin x = wa;        y = wa;        end
      4'hD: begin x = wa | wb;   y = wa;        end
      4'hE: begin x = wa | ~wb;  y = wa;        end
      default: begin x = wa;     y = mask;      end
    endcase
    case (s)
      4'h0: lg = ~wa;
      4'h1: lg = ~(wa | wb);
      4'h2: lg = ~wa & wb;
      4'h3: lg = 32'h0;
      4'h4: lg = ~(wa & wb);
      4'h5: lg = ~wb;
      4'h6: lg = wa ^ wb;
      4'h7: lg = wa & ~wb;
      4'h8: lg = ~wa | wb;
      4'h9: lg = ~(wa ^ wb);
      4'hA: lg = wb;
      4'hB: lg = wa & wb;
      4'hC: lg = 32'hFFFF_FFFF;
      4'hD: lg = wa | ~wb;
      4'hE: lg = wa | wb;
      default: lg = wa;
    endcase
    sum = (x & mask) + (y & mask) + {31'h0, ~cn};
    f   = (m ? lg : sum) & mask;
    return {~sum[nbits], f[15:0]};
  endfunction

  // Stand-in for the 4-bit slice sitting downstream of the sequencer.
  always_comb begin
    aluRes = evalOp({12'h0, alu_a}, {12'h0, alu_b}, alu_s, alu_m, alu_cn, 4);
  end
  assign alu_f      = aluRes[3:0];
  assign alu_cn_out = aluRes[16];
  assign alu_a_eq_b = &aluRes[3:0];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) begin
      passCount++;
    end else begin
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full operation: idle checks, accept, per-nibble slice checks, result
  // checks, optional consumer stall, then release back to IDLE.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                               input logic m, input logic cn, input int stall, input string tag);
    logic [16:0] r, rk;
    logic [15:0] expF;
    logic        expCn, expEq, expCarry;
    r     = evalOp(a, b, s, m, cn, 16);
    expF  = r[15:0];
    expCn = r[16];
    expEq = &expF;

    @(negedge clk);
    checkOutput($sformatf("%s idle in_ready", tag), 32'(in_ready), 32'd1);
    checkOutput($sformatf("%s idle out_valid", tag), 32'(out_valid), 32'd0);
    checkOutput($sformatf("%s idle out_f held", tag), 32'(out_f), 32'(lastF));
    checkOutput($sformatf("%s idle out_cn held", tag), 32'(out_cn), 32'(lastCn));
    checkOutput($sformatf("%s idle out_a_eq_b held", tag), 32'(out_a_eq_b), 32'(lastEq));
    checkOutput($sformatf("%s idle alu drive", tag), {19'h0, alu_a, alu_b, alu_s, alu_m},
                32'd0);
    checkOutput($sformatf("%s idle alu_cn", tag), 32'(alu_cn), 32'd0);
    in_a     = a;
    in_b     = b;
    in_s     = s;
    in_m     = m;
    in_cn    = cn;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = 16'($urandom);
    in_b     = 16'($urandom);
    in_s     = 4'($urandom);
    in_m     = 1'($urandom);
    in_cn    = 1'($urandom);

    for (int k = 0; k < NIBBLES; k++) begin
      @(negedge clk);
      if (k == 0) begin
        expCarry = cn;
      end else begin
        rk       = evalOp(a, b, s, m, cn, 4 * k);
        expCarry = rk[16];
      end
      checkOutput($sformatf("%s run%0d in_ready", tag, k), 32'(in_ready), 32'd0);
      checkOutput($sformatf("%s run%0d out_valid", tag, k), 32'(out_valid), 32'd0);
      checkOutput($sformatf("%s run%0d alu_a", tag, k), 32'(alu_a), 32'(a[4*k +: 4]));
      checkOutput($sformatf("%s run%0d alu_b", tag, k), 32'(alu_b), 32'(b[4*k +: 4]));
      checkOutput($sformatf("%s run%0d alu_s/m", tag, k), {27'h0, alu_s, alu_m}, {27'h0, s, m});
      checkOutput($sformatf("%s run%0d alu_cn", tag, k), 32'(alu_cn), 32'(expCarry));
    end

    @(negedge clk);
    checkOutput($sformatf("%s done out_valid", tag), 32'(out_valid), 32'd1);
    checkOutput($sformatf("%s done in_ready", tag), 32'(in_ready), 32'd0);
    checkOutput($sformatf("%s done out_f", tag), 32'(out_f), 32'(expF));
    checkOutput($sformatf("%s done out_cn", tag), 32'(out_cn), 32'(expCn));
    checkOutput($sformatf("%s done out_a_eq_b", tag), 32'(out_a_eq_b), 32'(expEq));
    checkOutput($sformatf("%s done alu_a", tag), 32'(alu_a), 32'd0);

    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checkOutput($sformatf("%s stall%0d out_valid", tag, i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("%s stall%0d out_f", tag, i), 32'(out_f), 32'(expF));
      checkOutput($sformatf("%s stall%0d in_ready", tag, i), 32'(in_ready), 32'd0);
    end

    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    lastF  = expF;
    lastCn = expCn;
    lastEq = expEq;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = 16'h0;
    in_b      = 16'h0;
    in_s      = 4'h0;
    in_m      = 1'b0;
    in_cn     = 1'b0;
    out_ready = 1'b0;
    lastF     = 16'h0;
    lastCn    = 1'b0;
    lastEq    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Add with a full-word carry out.
    applyStimulus(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 0, "add");
    checkOutput("add literal out_f", 32'(out_f), 32'h0000);
    checkOutput("add literal out_cn", 32'(out_cn), 32'd0);

    // Carry rippling across three nibbles.
    applyStimulus(16'h0FFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 0, "ripple");
    checkOutput("ripple literal out_f", 32'(out_f), 32'h1000);
    checkOutput("ripple literal out_cn", 32'(out_cn), 32'd1);

    // A minus B minus 1 as a comparator.
    applyStimulus(16'h1234, 16'h1234, 4'b0110, 1'b0, 1'b1, 0, "cmpEq");
    checkOutput("cmpEq literal out_f", 32'(out_f), 32'hFFFF);
    checkOutput("cmpEq literal eq", 32'(out_a_eq_b), 32'd1);
    applyStimulus(16'h1235, 16'h1234, 4'b0110, 1'b0, 1'b1, 0, "cmpNe");
    checkOutput("cmpNe literal eq", 32'(out_a_eq_b), 32'd0);

    // Logic XOR.
    applyStimulus(16'hA5A5, 16'h0FF0, 4'b0110, 1'b1, 1'b0, 0, "xor");
    checkOutput("xor literal out_f", 32'(out_f), 32'hAA55);

    // Consumer stall followed by an immediately accepted operation.
    applyStimulus(16'h7FFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 5, "stall");
    applyStimulus(16'h1111, 16'h2222, 4'b1001, 1'b0, 1'b0, 0, "b2b");

    // Reset while the third nibble is on the slice.
    @(negedge clk);
    checkOutput("rstMid in_ready", 32'(in_ready), 32'd1);
    in_a     = 16'h1357;
    in_b     = 16'h2468;
    in_s     = 4'b1001;
    in_m     = 1'b0;
    in_cn    = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstMid alu_a nibble2", 32'(alu_a), 32'h3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    lastF  = 16'h0;
    lastCn = 1'b0;
    lastEq = 1'b0;
    applyStimulus(16'h00FF, 16'h0F0F, 4'b1001, 1'b0, 1'b1, 0, "afterRst");

    // Randomised operations with random consumer stalls.
    for (int n = 0; n < 40; n++) begin
      applyStimulus(16'($urandom), 16'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                    int'($urandom_range(0, 3)), $sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
